// File: rtl/qdec_pkg.sv
// Shared encodings and Gray-code step lookups for the quadrature decoder array.
// Error detection in qdec_channel is compiled in only when QDEC_ERR_EN is defined.
package qdec_pkg;

  localparam logic [1:0] QDEC_X1 = 2'd0;
  localparam logic [1:0] QDEC_X2 = 2'd1;
  localparam logic [1:0] QDEC_X4 = 2'd2;

  localparam logic [1:0] QDEC_S00 = 2'b00;
  localparam logic [1:0] QDEC_S01 = 2'b01;
  localparam logic [1:0] QDEC_S11 = 2'b11;
  localparam logic [1:0] QDEC_S10 = 2'b10;

  typedef struct packed {
    logic up;
    logic dn;
  } qdec_evt_t;

  function automatic logic [1:0] qdec_next_up(input logic [1:0] s);
    case (s)
      QDEC_S00: return QDEC_S01;
      QDEC_S01: return QDEC_S11;
      QDEC_S11: return QDEC_S10;
      default:  return QDEC_S00;
    endcase
  endfunction

  function automatic logic [1:0] qdec_next_down(input logic [1:0] s);
    case (s)
      QDEC_S00: return QDEC_S10;
      QDEC_S10: return QDEC_S11;
      QDEC_S11: return QDEC_S01;
      default:  return QDEC_S00;
    endcase
  endfunction

endpackage

// File: rtl/qdec_channel.sv
// One encoder channel: 2-flop sync, run-length glitch filter, Gray decoder, wrap counter.
// Illegal-transition flag is built only when QDEC_ERR_EN is defined.
//
// filt (decoder state) | meaning
// 00 | phase A low,  phase B low
// 01 | phase A low,  phase B high
// 11 | phase A high, phase B high
// 10 | phase A high, phase B low
// valid=0 means no value accepted since reset; the first accept only seeds filt.
module qdec_channel
  import qdec_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int FILT_DEPTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x,
  input  logic             y,
  input  logic [1:0]       mode,
  input  logic             clr,
  output logic [CNT_W-1:0] counter,
  output logic             step,
  output logic             dir,
  output logic             err
);

  localparam logic [3:0]       RUN_MAX = 4'(FILT_DEPTH);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [1:0] sync1, sync2, cand, filt;
  logic [3:0] run;
  logic       valid;
  logic       pending, accept, is_up, is_dn, hit;
  qdec_evt_t  evt;

  always_comb begin
    pending = (cand != filt) || !valid;
    accept  = (sync2 == cand) && pending && (run >= RUN_MAX);
    is_up   = (cand == qdec_next_up(filt));
    is_dn   = (cand == qdec_next_down(filt));
    case (mode)
      QDEC_X1: hit = (cand == QDEC_S11);
      QDEC_X2: hit = (cand == QDEC_S11) || (cand == QDEC_S00);
      default: hit = 1'b1;
    endcase
  end

  // cand tracks the synced pair; run counts how long it has stayed put.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= QDEC_S00;
      sync2 <= QDEC_S00;
      cand  <= QDEC_S00;
      filt  <= QDEC_S00;
      run   <= 4'd0;
      valid <= 1'b0;
      evt   <= '0;
    end else begin
      sync1 <= {x, y};
      sync2 <= sync1;
      evt   <= '0;
      if (sync2 != cand) begin
        cand <= sync2;
        run  <= 4'd1;
      end else if (accept) begin
        filt   <= cand;
        valid  <= 1'b1;
        run    <= 4'd0;
        evt.up <= valid && is_up && hit;
        evt.dn <= valid && is_dn && hit;
      end else if (pending) begin
        run <= run + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      counter <= '0;
      step    <= 1'b0;
      dir     <= 1'b0;
    end else begin
      step <= 1'b0;
      if (clr) begin
        counter <= '0;
      end else if (evt.up) begin
        counter <= counter + ONE;
        step    <= 1'b1;
        dir     <= 1'b1;
      end else if (evt.dn) begin
        counter <= counter - ONE;
        step    <= 1'b1;
        dir     <= 1'b0;
      end
    end
  end

`ifdef QDEC_ERR_EN
  logic illegal;

  always_ff @(posedge clk) begin
    if (reset) begin
      illegal <= 1'b0;
      err     <= 1'b0;
    end else begin
      illegal <= (sync2 == cand) && accept && valid && !is_up && !is_dn;
      if (clr)          err <= 1'b0;
      else if (illegal) err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: rtl/quad_decoder_array.sv
// Array of independent quadrature decoder channels sharing one resolution mode.
// Define QDEC_ERR_EN to enable per-channel illegal-transition detection.
module quad_decoder_array
  import qdec_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int CNT_W      = 16,
  parameter int FILT_DEPTH = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       x,
  input  logic [CHANNELS-1:0]       y,
  input  logic [1:0]                mode,
  input  logic [CHANNELS-1:0]       clr,
  output logic [CHANNELS*CNT_W-1:0] counter,
  output logic [CHANNELS-1:0]       step,
  output logic [CHANNELS-1:0]       dir,
  output logic [CHANNELS-1:0]       err
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    qdec_channel #(
      .CNT_W     (CNT_W),
      .FILT_DEPTH(FILT_DEPTH)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .x      (x[i]),
      .y      (y[i]),
      .mode   (mode),
      .clr    (clr[i]),
      .counter(counter[i*CNT_W +: CNT_W]),
      .step   (step[i]),
      .dir    (dir[i]),
      .err    (err[i])
    );
  end

endmodule
